// File: rtl/sum_frame_accumulator_pkg.sv
// Shared constants and state type for the sum-of-N frame accumulator.
package sum_frame_accumulator_pkg;

  localparam int N_W     = 4;
  localparam int SUM_W   = 7;
  localparam int SUM_MAX = 120;

  typedef enum logic {ACC, HOLD} state_t;

  // Triangular number n*(n+1)/2; 8-bit product holds 15*16 = 240.
  function automatic logic [SUM_W-1:0] tri_num(input logic [N_W-1:0] n);
    logic [7:0] p;
    p = {4'b0, n} * ({4'b0, n} + 8'd1);
    return SUM_W'(p >> 1);
  endfunction

endpackage

// File: rtl/sum_frame_accumulator_if.sv
// Sample-in / frame-result-out handshake bundle for sum_frame_accumulator.
interface sum_frame_accumulator_if
  import sum_frame_accumulator_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int TOT_W     = 10
) ();
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [N_W-1:0]   in_n;
  logic [SUM_W-1:0] in_s;
  logic             in_last;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [TOT_W-1:0] out_total;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;
  logic             err;

  modport master (
    output in_valid, in_n, in_s, in_last, flush, out_ready,
    input  in_ready, out_valid, out_total, out_count, out_sat, err
  );

  modport slave (
    input  in_valid, in_n, in_s, in_last, flush, out_ready,
    output in_ready, out_valid, out_total, out_count, out_sat, err
  );
endinterface

// File: rtl/sum_frame_accumulator_nsum_ref_check.sv
// Recomputes n*(n+1)/2 and flags a sample whose S disagrees with its N.
module nsum_ref_check
  import sum_frame_accumulator_pkg::*;
(
  input  logic [N_W-1:0]   n_i,
  input  logic [SUM_W-1:0] s_i,
  output logic             mismatch_o
);
  assign mismatch_o = (tri_num(n_i) != s_i);
endmodule

// File: rtl/sum_frame_accumulator.sv
// Accumulates S over a frame of up to FRAME_LEN samples and hands the total out.
// Optional sum checker enabled by defining SUM_CHECK_EN.
module sum_frame_accumulator
  import sum_frame_accumulator_pkg::*;
#(
  parameter int FRAME_LEN = 8,
  parameter int TOT_W     = 10
) (
  input logic clk,
  input logic rst_n,
  sum_frame_accumulator_if.slave bus
);
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  state_t           state_q;
  logic [TOT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             out_valid_q, out_sat_q;
  logic [TOT_W-1:0] out_total_q;
  logic [CNT_W-1:0] out_count_q;
  logic [TOT_W:0]   sum_wide;
  logic             frame_end;

  // One extra bit catches overflow; once saturated, acc stays all-ones.
  assign sum_wide  = {1'b0, acc_q} + {{(TOT_W+1-SUM_W){1'b0}}, bus.in_s};
  assign sat_d     = sat_q | sum_wide[TOT_W];
  assign acc_d     = sum_wide[TOT_W] ? {TOT_W{1'b1}} : sum_wide[TOT_W-1:0];
  assign cnt_d     = cnt_q + CNT_W'(1);
  assign frame_end = (cnt_d == CNT_W'(FRAME_LEN)) || bus.in_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_total_q <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
    end else if (bus.flush) begin
      state_q     <= ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: if (bus.in_valid) begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          sat_q <= sat_d;
          if (frame_end) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_total_q <= acc_d;
            out_count_q <= cnt_d;
            out_sat_q   <= sat_d;
          end
        end
        HOLD: if (out_valid_q && bus.out_ready) begin
          state_q     <= ACC;
          acc_q       <= '0;
          cnt_q       <= '0;
          sat_q       <= 1'b0;
          out_valid_q <= 1'b0;
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ACC);
  assign bus.out_valid = out_valid_q;
  assign bus.out_total = out_total_q;
  assign bus.out_count = out_count_q;
  assign bus.out_sat   = out_sat_q;

`ifdef SUM_CHECK_EN
  logic mismatch, err_q;

  nsum_ref_check u_chk (
    .n_i        (bus.in_n),
    .s_i        (bus.in_s),
    .mismatch_o (mismatch)
  );

  // Flush does not clear the error; only reset does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                  err_q <= 1'b0;
    else if (!bus.flush && state_q == ACC && bus.in_valid && mismatch) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  logic unused_n;
  assign unused_n = ^bus.in_n;
  assign bus.err  = 1'b0;
`endif

endmodule

// File: tb/tb_sum_frame_accumulator.sv
// Directed bench for sum_frame_accumulator: main (8/10), saturating (8/8) and single-sample (1/10) instances.
module tb_sum_frame_accumulator;
  import sum_frame_accumulator_pkg::*;

`ifdef SUM_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic [6:0] tri_tbl [1:8] = '{7'd1, 7'd3, 7'd6, 7'd10, 7'd15, 7'd21, 7'd28, 7'd36};

  always #5 clk = ~clk;

  sum_frame_accumulator_if #(.FRAME_LEN(8), .TOT_W(10)) b8 ();
  sum_frame_accumulator_if #(.FRAME_LEN(8), .TOT_W(8))  bs ();
  sum_frame_accumulator_if #(.FRAME_LEN(1), .TOT_W(10)) b1 ();

  sum_frame_accumulator #(.FRAME_LEN(8), .TOT_W(10)) u_dut (.clk(clk), .rst_n(rst_n), .bus(b8));
  sum_frame_accumulator #(.FRAME_LEN(8), .TOT_W(8))  u_sat (.clk(clk), .rst_n(rst_n), .bus(bs));
  sum_frame_accumulator #(.FRAME_LEN(1), .TOT_W(10)) u_one (.clk(clk), .rst_n(rst_n), .bus(b1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send8(input int n, input int s, input logic last);
    b8.in_valid = 1'b1; b8.in_n = 4'(n); b8.in_s = 7'(s); b8.in_last = last;
    step();
    b8.in_valid = 1'b0; b8.in_last = 1'b0;
  endtask

  task automatic frame_1_to_8(input logic last_on_8th);
    for (int i = 1; i <= 8; i++) send8(i, int'(tri_tbl[i]), (i == 8) ? last_on_8th : 1'b0);
  endtask

  initial begin
    b8.in_valid = 0; b8.in_n = 0; b8.in_s = 0; b8.in_last = 0; b8.flush = 0; b8.out_ready = 0;
    bs.in_valid = 0; bs.in_n = 0; bs.in_s = 0; bs.in_last = 0; bs.flush = 0; bs.out_ready = 0;
    b1.in_valid = 0; b1.in_n = 0; b1.in_s = 0; b1.in_last = 0; b1.flush = 0; b1.out_ready = 0;
    step(); step();

    chk("rst_out_valid", b8.out_valid, 0);
    chk("rst_out_total", b8.out_total, 0);
    chk("rst_out_count", b8.out_count, 0);
    chk("rst_out_sat",   b8.out_sat,   0);
    chk("rst_err",       b8.err,       0);
    chk("rst_in_ready",  b8.in_ready,  1);
    @(negedge clk); rst_n = 1'b1;
    step();

    // Full frame of 8, result one cycle after the 8th accept
    b8.out_ready = 1'b1;
    for (int i = 1; i <= 7; i++) send8(i, int'(tri_tbl[i]), 1'b0);
    chk("full_no_early_valid", b8.out_valid, 0);
    send8(8, 36, 1'b0);
    chk("full_valid", b8.out_valid, 1);
    chk("full_total", b8.out_total, 120);
    chk("full_count", b8.out_count, 8);
    chk("full_sat",   b8.out_sat,   0);
    chk("full_in_ready_hold", b8.in_ready, 0);
    step();
    chk("full_handshake_valid", b8.out_valid, 0);
    chk("full_back_to_acc", b8.in_ready, 1);
    chk("full_err", b8.err, 0);

    // Early end with in_last, then backpressure for 5 cycles with ignored input
    b8.out_ready = 1'b0;
    send8(4, 10, 1'b0);
    send8(5, 15, 1'b0);
    send8(15, 120, 1'b1);
    chk("early_valid", b8.out_valid, 1);
    chk("early_total", b8.out_total, 145);
    chk("early_count", b8.out_count, 3);
    b8.in_valid = 1'b1; b8.in_n = 4'd1; b8.in_s = 7'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_in_ready", b8.in_ready, 0);
      chk("hold_valid", b8.out_valid, 1);
      chk("hold_total", b8.out_total, 145);
      chk("hold_count", b8.out_count, 3);
    end
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    step();
    chk("hold_release_valid", b8.out_valid, 0);
    chk("hold_release_ready", b8.in_ready, 1);
    send8(2, 3, 1'b1);
    chk("single_last_total", b8.out_total, 3);
    chk("single_last_count", b8.out_count, 1);
    step();

    // in_last without in_valid is ignored
    b8.in_last = 1'b1;
    step();
    b8.in_last = 1'b0;
    chk("last_no_valid", b8.out_valid, 0);

    // in_last on the 8th sample gives exactly one result
    frame_1_to_8(1'b1);
    chk("last8_count", b8.out_count, 8);
    chk("last8_total", b8.out_total, 120);
    step();
    step();
    chk("last8_single_result", b8.out_valid, 0);

    // Flush in ACC with a sample presented in the same cycle
    send8(2, 3, 1'b0);
    send8(3, 6, 1'b0);
    send8(4, 10, 1'b0);
    b8.flush = 1'b1; b8.in_valid = 1'b1; b8.in_n = 4'd5; b8.in_s = 7'd15;
    step();
    b8.flush = 1'b0; b8.in_valid = 1'b0;
    chk("flush_acc_valid", b8.out_valid, 0);
    chk("flush_acc_ready", b8.in_ready, 1);
    frame_1_to_8(1'b0);
    chk("flush_next_total", b8.out_total, 120);
    chk("flush_next_count", b8.out_count, 8);
    step();

    // Flush in HOLD drops the pending result
    b8.out_ready = 1'b0;
    send8(3, 6, 1'b1);
    chk("flush_hold_pending", b8.out_valid, 1);
    b8.flush = 1'b1;
    step();
    b8.flush = 1'b0;
    chk("flush_hold_valid", b8.out_valid, 0);
    chk("flush_hold_ready", b8.in_ready, 1);
    chk("flush_hold_total_kept", b8.out_total, 6);

    // Sum checker: wrong S for N=3 still accumulates
    b8.out_ready = 1'b0;
    send8(3, 7, 1'b0);
    send8(1, 1, 1'b1);
    chk("chk_total", b8.out_total, 8);
    chk("chk_count", b8.out_count, 2);
    chk("chk_err",   b8.err, 32'(ERR_EXP));
    b8.flush = 1'b1;
    step();
    b8.flush = 1'b0;
    chk("chk_err_after_flush", b8.err, 32'(ERR_EXP));

    // Asynchronous reset mid-frame after 5 samples
    b8.out_ready = 1'b1;
    frame_1_to_8(1'b0);
    step();
    for (int i = 1; i <= 5; i++) send8(i, int'(tri_tbl[i]), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", b8.out_valid, 0);
    chk("arst_total", b8.out_total, 0);
    chk("arst_count", b8.out_count, 0);
    chk("arst_err",   b8.err, 0);
    chk("arst_ready", b8.in_ready, 1);
    @(negedge clk); rst_n = 1'b1;
    frame_1_to_8(1'b0);
    chk("arst_next_total", b8.out_total, 120);
    chk("arst_next_count", b8.out_count, 8);
    step();

    // Saturation with TOT_W=8: 8 x 120 clamps at 255
    bs.out_ready = 1'b1;
    bs.in_valid = 1'b1; bs.in_n = 4'd15; bs.in_s = 7'd120;
    for (int i = 0; i < 8; i++) step();
    bs.in_valid = 1'b0;
    chk("sat_total", bs.out_total, 255);
    chk("sat_flag",  bs.out_sat, 1);
    chk("sat_count", bs.out_count, 8);
    step();
    bs.in_valid = 1'b1; bs.in_n = 4'd1; bs.in_s = 7'd1;
    for (int i = 0; i < 8; i++) step();
    bs.in_valid = 1'b0;
    chk("sat_clear_total", bs.out_total, 8);
    chk("sat_clear_flag",  bs.out_sat, 0);

    // FRAME_LEN=1: every accepted sample is a result, including N=0
    b1.out_ready = 1'b1;
    b1.in_valid = 1'b1; b1.in_n = 4'd2; b1.in_s = 7'd3;
    step();
    b1.in_valid = 1'b0;
    chk("one_valid", b1.out_valid, 1);
    chk("one_total", b1.out_total, 3);
    chk("one_count", b1.out_count, 1);
    step();
    chk("one_handshake", b1.out_valid, 0);
    b1.in_valid = 1'b1; b1.in_n = 4'd0; b1.in_s = 7'd0;
    step();
    b1.in_valid = 1'b0;
    chk("one_zero_valid", b1.out_valid, 1);
    chk("one_zero_total", b1.out_total, 0);
    chk("one_zero_count", b1.out_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
